// File: rtl/gbuff_out_writer_pkg.sv
// Shared constants, writer state encoding and address helper for the
// GBUFF_OUT result writeback path.
package gbuff_out_writer_pkg;

    localparam int DATA_SIZE = 8;
    localparam int WORD_SIZE = 32;
    localparam int ADDR_SIZE = 16;
    localparam int DIM_SIZE  = 4;
    localparam int LANES     = WORD_SIZE / DATA_SIZE;
    localparam int LANE_W    = $clog2(LANES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } wr_state_e;

    // Words per output row: ceil(n/LANES), widened first so n=15 cannot wrap.
    function automatic logic [ADDR_SIZE-1:0] words_per_row(input logic [DIM_SIZE-1:0] n);
        logic [ADDR_SIZE-1:0] tmp;
        tmp = ADDR_SIZE'(n) + ADDR_SIZE'(LANES - 1);
        return tmp >> LANE_W;
    endfunction

endpackage

// File: rtl/gbuff_out_writer_if.sv
// Command, result-stream and GBUFF_OUT write bus of the writeback stage.
// master = producer/controller side, slave = gbuff_out_writer.
interface gbuff_out_writer_if;
    import gbuff_out_writer_pkg::*;

    logic                 start;
    logic [DIM_SIZE-1:0]  m;
    logic [DIM_SIZE-1:0]  n;
    logic                 res_valid;
    logic [DATA_SIZE-1:0] res_data;
    logic                 res_ready;
    logic                 wr_en;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [WORD_SIZE-1:0] wr_data;
    logic                 done;

    modport master (
        output start, m, n, res_valid, res_data,
        input  res_ready, wr_en, wr_addr, wr_data, done
    );

    modport slave (
        input  start, m, n, res_valid, res_data,
        output res_ready, wr_en, wr_addr, wr_data, done
    );

endinterface

// File: rtl/gbuff_word_packer.sv
// Packs accepted result bytes into GBUFF_OUT words and registers the write.
// Build option: GBUFF_OUT_BYTE_SWAP_EN puts lane 0 in the most significant byte.
module gbuff_word_packer
    import gbuff_out_writer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_accept,
    input  logic                 i_emit,
    input  logic [LANE_W-1:0]    i_lane,
    input  logic [DATA_SIZE-1:0] i_data,
    output logic                 o_wr_en,
    output logic [WORD_SIZE-1:0] o_wr_data
);

    logic [WORD_SIZE-1:0] r_pack;
    logic [WORD_SIZE-1:0] r_wr_data;
    logic                 r_wr_en;
    logic [LANE_W-1:0]    w_shamt;
    logic [WORD_SIZE-1:0] w_ins;
    logic [WORD_SIZE-1:0] w_merged;

`ifdef GBUFF_OUT_BYTE_SWAP_EN
    assign w_shamt = LANE_W'(LANES - 1) - i_lane;
`else
    assign w_shamt = i_lane;
`endif

    assign w_ins    = WORD_SIZE'(i_data) << (32'(w_shamt) * DATA_SIZE);
    assign w_merged = r_pack | w_ins;

    // Accumulate lanes; on emit hand the word to the write register and clear the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pack    <= '0;
            r_wr_data <= '0;
            r_wr_en   <= 1'b0;
        end else if (i_accept) begin
            if (i_emit) begin
                r_wr_data <= w_merged;
                r_pack    <= '0;
                r_wr_en   <= 1'b1;
            end else begin
                r_pack    <= w_merged;
                r_wr_en   <= 1'b0;
            end
        end else begin
            r_wr_en <= 1'b0;
        end
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_data = r_wr_data;

endmodule

// File: rtl/gbuff_out_writer.sv
// Result writeback stage: sequences an m x n byte stream into GBUFF_OUT words,
// ceil(n/4) words per row. Build option GBUFF_OUT_BYTE_SWAP_EN (lane order, in packer).
module gbuff_out_writer
    import gbuff_out_writer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    gbuff_out_writer_if.slave  bus
);

    wr_state_e            r_state;
    wr_state_e            w_next_state;
    logic [DIM_SIZE-1:0]  r_m;
    logic [DIM_SIZE-1:0]  r_n;
    logic [DIM_SIZE-1:0]  r_row;
    logic [DIM_SIZE-1:0]  r_col;
    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] w_addr;
    logic                 w_start_ok;
    logic                 w_zero_dim;
    logic                 w_accept;
    logic                 w_last_col;
    logic                 w_last_row;
    logic                 w_emit;
    logic                 w_res_ready;
    logic                 w_done;
    logic                 w_wr_en;
    logic [WORD_SIZE-1:0] w_wr_data;

    assign w_start_ok = bus.start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_zero_dim = (bus.m == DIM_SIZE'(0)) | (bus.n == DIM_SIZE'(0));
    assign w_accept   = bus.res_valid & w_res_ready;
    assign w_last_col = (r_col == (r_n - DIM_SIZE'(1)));
    assign w_last_row = (r_row == (r_m - DIM_SIZE'(1)));
    assign w_emit     = w_accept & ((r_col[LANE_W-1:0] == LANE_W'(LANES - 1)) | w_last_col);
    // Address of the word the current byte completes; 16-bit product cannot overflow for m,n<=15.
    assign w_addr     = ADDR_SIZE'(r_row) * words_per_row(r_n) + (ADDR_SIZE'(r_col) >> LANE_W);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; an empty matrix goes straight to DONE without writes.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_next_state = w_zero_dim ? ST_DONE : ST_ACTIVE;
                end else begin
                    w_next_state = r_state;
                end
            end
            ST_ACTIVE: begin
                if (w_accept && w_last_col && w_last_row) begin
                    w_next_state = ST_FLUSH;
                end else begin
                    w_next_state = ST_ACTIVE;
                end
            end
            ST_FLUSH: w_next_state = ST_DONE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        w_res_ready = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_ACTIVE: w_res_ready = 1'b1;
            ST_DONE:   w_done      = 1'b1;
            default: begin
                w_res_ready = 1'b0;
                w_done      = 1'b0;
            end
        endcase
    end

    // Dimension capture on start, row/col advance on each accepted byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m   <= '0;
            r_n   <= '0;
            r_row <= '0;
            r_col <= '0;
        end else if (w_start_ok) begin
            r_m   <= bus.m;
            r_n   <= bus.n;
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= r_row + DIM_SIZE'(1);
            end else begin
                r_col <= r_col + DIM_SIZE'(1);
            end
        end
    end

    // Write address registered alongside the packed word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr <= '0;
        end else if (w_emit) begin
            r_wr_addr <= w_addr;
        end
    end

    gbuff_word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_accept  (w_accept),
        .i_emit    (w_emit),
        .i_lane    (r_col[LANE_W-1:0]),
        .i_data    (bus.res_data),
        .o_wr_en   (w_wr_en),
        .o_wr_data (w_wr_data)
    );

    assign bus.res_ready = w_res_ready;
    assign bus.done      = w_done;
    assign bus.wr_en     = w_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = w_wr_data;

endmodule

// File: tb/tb_gbuff_out_writer.sv
// Directed bench for gbuff_out_writer; honours GBUFF_OUT_BYTE_SWAP_EN for expected words.
module tb_gbuff_out_writer;
    import gbuff_out_writer_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gbuff_out_writer_if bus();

    gbuff_out_writer u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int last_wr_cyc   = -1;
    int done_rise_cyc = -1;
    int overlap_cnt   = 0;
    logic done_q = 1'b0;
    logic [15:0] q_addr[$];
    logic [31:0] q_data[$];

    // Write/done monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.wr_en) begin
            q_addr.push_back(bus.wr_addr);
            q_data.push_back(bus.wr_data);
            last_wr_cyc = cyc;
        end
        if (bus.done && !done_q) done_rise_cyc = cyc;
        if (bus.wr_en && bus.done) overlap_cnt = overlap_cnt + 1;
        done_q = bus.done;
    end

    function automatic logic [31:0] pack4(input logic [7:0] c0, input logic [7:0] c1,
                                          input logic [7:0] c2, input logic [7:0] c3);
`ifdef GBUFF_OUT_BYTE_SWAP_EN
        return {c0, c1, c2, c3};
`else
        return {c3, c2, c1, c0};
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [15:0] ea, input logic [31:0] ed);
        check({tag, "_present"}, 32'(q_addr.size() > idx), 32'd1);
        if (q_addr.size() > idx) begin
            check({tag, "_addr"}, 32'(q_addr[idx]), 32'(ea));
            check({tag, "_data"}, q_data[idx], ed);
        end
    endtask

    task automatic clear_q();
        q_addr.delete();
        q_data.delete();
    endtask

    // Pulse start for one cycle; returns at the negedge after start was sampled.
    task automatic send_start(input logic [3:0] mm, input logic [3:0] nn);
        @(negedge clk);
        bus.start = 1'b1;
        bus.m     = mm;
        bus.n     = nn;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Stream count bytes base+idx; with toggle, res_valid idles every other cycle.
    task automatic send_bytes(input string tag, input int count, input bit toggle, input logic [7:0] base);
        int idx = 0;
        int guard = 0;
        while (idx < count && guard < 400) begin
            if (toggle && guard[0]) begin
                bus.res_valid = 1'b0;
                bus.res_data  = 8'hEE;
            end else begin
                bus.res_valid = 1'b1;
                bus.res_data  = base + 8'(idx);
                if (bus.res_ready) idx = idx + 1;
            end
            @(negedge clk);
            guard = guard + 1;
        end
        bus.res_valid = 1'b0;
        check({tag, "_accepted"}, 32'(idx), 32'(count));
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        @(negedge clk);
        #1;
        while (!bus.done && k < 50) begin
            @(negedge clk);
            #1;
            k = k + 1;
        end
        check({tag, "_done"}, 32'(bus.done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_res_ready"}, 32'(bus.res_ready), 32'd0);
        check({tag, "_wr_en"},     32'(bus.wr_en),     32'd0);
        check({tag, "_wr_addr"},   32'(bus.wr_addr),   32'd0);
        check({tag, "_wr_data"},   bus.wr_data,        32'd0);
        check({tag, "_done"},      32'(bus.done),      32'd0);
    endtask

    initial begin
        logic [7:0] b;
        bus.start = 1'b0; bus.m = '0; bus.n = '0;
        bus.res_valid = 1'b0; bus.res_data = '0;

        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // 1: m=2 n=4
        clear_q();
        send_start(4'd2, 4'd4);
        send_bytes("t1", 8, 1'b0, 8'h01);
        wait_done("t1");
        check("t1_nwr", 32'(q_addr.size()), 32'd2);
        check_wr("t1_w0", 0, 16'd0, pack4(8'h01, 8'h02, 8'h03, 8'h04));
        check_wr("t1_w1", 1, 16'd1, pack4(8'h05, 8'h06, 8'h07, 8'h08));
        check("t1_done_lat", 32'(done_rise_cyc - last_wr_cyc), 32'd1);
        // res_valid while not ready is ignored
        bus.res_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.res_valid = 1'b0;
        #1;
        check("t1_idle_nwr", 32'(q_addr.size()), 32'd2);
        check("t1_idle_done", 32'(bus.done), 32'd1);

        // 2: m=3 n=5, partial end-of-row words zero-filled
        clear_q();
        send_start(4'd3, 4'd5);
        send_bytes("t2", 15, 1'b0, 8'h10);
        wait_done("t2");
        check("t2_nwr", 32'(q_addr.size()), 32'd6);
        for (int r = 0; r < 3; r++) begin
            b = 8'h10 + 8'(5 * r);
            check_wr("t2_full", 2 * r, 16'(2 * r), pack4(b, b + 8'd1, b + 8'd2, b + 8'd3));
            check_wr("t2_part", 2 * r + 1, 16'(2 * r + 1), pack4(b + 8'd4, 8'h00, 8'h00, 8'h00));
        end

        // 3: m=1 n=12 with idle cycles between bytes
        clear_q();
        send_start(4'd1, 4'd12);
        send_bytes("t3", 12, 1'b1, 8'h20);
        wait_done("t3");
        check("t3_nwr", 32'(q_addr.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            b = 8'h20 + 8'(4 * i);
            check_wr("t3_w", i, 16'(i), pack4(b, b + 8'd1, b + 8'd2, b + 8'd3));
        end

        // 4: empty matrices, then restart from DONE with 1x1
        clear_q();
        send_start(4'd0, 4'd5);
        #1;
        check("t4_m0_done", 32'(bus.done), 32'd1);
        send_start(4'd3, 4'd0);
        #1;
        check("t4_n0_done", 32'(bus.done), 32'd1);
        check("t4_empty_nwr", 32'(q_addr.size()), 32'd0);
        send_start(4'd1, 4'd1);
        check("t4_done_drop", 32'(bus.done), 32'd0);
        check("t4_ready", 32'(bus.res_ready), 32'd1);
        send_bytes("t4", 1, 1'b0, 8'hAB);
        wait_done("t4");
        check("t4_nwr", 32'(q_addr.size()), 32'd1);
        check_wr("t4_w0", 0, 16'd0, pack4(8'hAB, 8'h00, 8'h00, 8'h00));

        // 5: reset during row 1 of m=4 n=8, then a full rerun
        send_start(4'd4, 4'd8);
        send_bytes("t5a", 12, 1'b0, 8'h40);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        send_start(4'd0, 4'd3);
        #1;
        check("t5_idle_zero_done", 32'(bus.done), 32'd1);
        send_start(4'd4, 4'd8);
        send_bytes("t5b", 32, 1'b0, 8'h40);
        wait_done("t5");
        check("t5_nwr", 32'(q_addr.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            b = 8'h40 + 8'(4 * i);
            check_wr("t5_w", i, 16'(i), pack4(b, b + 8'd1, b + 8'd2, b + 8'd3));
        end

        check("wr_done_overlap", 32'(overlap_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
